// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential signed ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (ADD, SUB, logic, shifts, illegal) go IDLE->DONE at accept.
// MUL and DIV go through BUSY for N cycles: MUL is shift-add and DIV is
// restoring division. Both run on operand magnitudes, and the signs are
// applied on the final cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operation handshake (in_ready = IDLE)
//   a, b                 signed N-bit operands
//   opcode               0 ADD 1 SUB 2 MUL 3 DIV 4 AND 5 OR 6 XOR 7 NOR
//                        8 SLL 9 SRA, 10-15 illegal
//   out_valid/out_ready  result handshake (out_valid = DONE)
//   result, remainder    primary / secondary result
//   carry_out, zero, overflow, div_by_zero, illegal_op   status flags
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] remainder,
    output logic         carry_out,
    output logic         zero,
    output logic         overflow,
    output logic         div_by_zero,
    output logic         illegal_op
);

    localparam int SW = $clog2(N);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOR = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    // Everything that gets loaded into the output registers; zero is derived.
    typedef struct packed {
        logic [N-1:0] res;
        logic [N-1:0] rem;
        logic         c;
        logic         v;
        logic         dbz;
        logic         ill;
    } res_t;

    state_e        state, state_next;
    logic          accept, iter_last, iter_op, load_en;
    logic [N-1:0]  a_q, b_q;
    logic          is_mul_q;
    logic [SW-1:0] cnt;
    logic [N-1:0]  hi, lo, hi_n, lo_n;
    logic [N:0]    mul_sum, div_shift, div_trial;
    logic [N:0]    wide;
    logic [SW-1:0] sh;
    logic          neg;
    logic [2*N-1:0] prod;
    res_t          quick, slow, load_val;

    function automatic logic [N-1:0] mag(input logic [N-1:0] x);
        return x[N-1] ? -x : x;
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign iter_op   = (opcode == OP_MUL) || (opcode == OP_DIV);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first -- every path assigns every output, so no latch.
        state_next = state;
        accept     = 1'b0;
        iter_last  = (cnt == SW'(N-1));
        case (state)
            S_IDLE: if (in_valid) begin
                accept     = 1'b1;
                state_next = iter_op ? S_BUSY : S_DONE;
            end
            S_BUSY: if (iter_last) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------- single-cycle ops (raw inputs)
    always_comb begin
        quick = '0;
        wide  = '0;
        sh    = b[SW-1:0];
        case (opcode)
            OP_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                quick.res = wide[N-1:0];
                quick.c   = wide[N];
                quick.v   = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
            end
            OP_SUB: begin
                wide      = {1'b0, a} - {1'b0, b};
                quick.res = wide[N-1:0];
                quick.c   = wide[N];                      // borrow == (a < b) unsigned
                quick.v   = (a[N-1] != b[N-1]) && (wide[N-1] != a[N-1]);
            end
            OP_AND: quick.res = a & b;
            OP_OR:  quick.res = a | b;
            OP_XOR: quick.res = a ^ b;
            OP_NOR: quick.res = ~(a | b);
            OP_SLL: begin
                // Spare MSB catches the last bit shifted out (0 when sh == 0).
                wide      = {1'b0, a} << sh;
                quick.res = wide[N-1:0];
                quick.c   = wide[N];
            end
            OP_SRA: begin
                // Spare LSB catches the last bit shifted out (0 when sh == 0).
                wide      = $signed({a, 1'b0}) >>> sh;
                quick.res = wide[N:1];
                quick.c   = wide[0];
            end
            OP_MUL, OP_DIV: ;                             // iterative path
            default: quick.ill = 1'b1;
        endcase
    end

    // ------------------------------------------------- one MUL / DIV iteration
    always_comb begin
        mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, mag(a_q)}) : {1'b0, hi};
        div_shift = {hi, lo[N-1]};
        div_trial = div_shift - {1'b0, mag(b_q)};
        if (is_mul_q) begin
            hi_n = mul_sum[N:1];
            lo_n = {mul_sum[0], lo[N-1:1]};
        end else if (!div_trial[N]) begin
            hi_n = div_trial[N-1:0];
            lo_n = {lo[N-2:0], 1'b1};
        end else begin
            hi_n = div_shift[N-1:0];
            lo_n = {lo[N-2:0], 1'b0};
        end
    end

    // ----------------------------- sign fix-up applied on the last iteration
    always_comb begin
        slow = '0;
        neg  = a_q[N-1] ^ b_q[N-1];
        prod = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
        if (is_mul_q) begin
            slow.res = prod[N-1:0];
            slow.rem = prod[2*N-1:N];
            slow.v   = (prod[2*N-1:N] != {N{prod[N-1]}});
        end else if (b_q == '0) begin
            slow.res = '1;
            slow.rem = a_q;
            slow.dbz = 1'b1;
        end else begin
            // MIN / -1 lands on MIN naturally (magnitude 2^(N-1) negated).
            slow.res = neg ? -lo_n : lo_n;
            slow.rem = a_q[N-1] ? -hi_n : hi_n;
            slow.v   = (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1);
        end
    end

    assign load_en  = (accept && !iter_op) || ((state == S_BUSY) && iter_last);
    assign load_val = (state == S_BUSY) ? slow : quick;

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state is plain flops (no RAM), so all of it is reset.
            a_q         <= '0;
            b_q         <= '0;
            is_mul_q    <= 1'b0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            result      <= '0;
            remainder   <= '0;
            carry_out   <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                is_mul_q <= (opcode == OP_MUL);
                cnt      <= '0;
                hi       <= '0;
                // MUL shifts the multiplier (|b|) out of lo; DIV shifts |a| in.
                lo       <= (opcode == OP_MUL) ? mag(b) : mag(a);
            end else if (state == S_BUSY) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + 1'b1;
            end
            if (load_en) begin
                result      <= load_val.res;
                remainder   <= load_val.rem;
                carry_out   <= load_val.c;
                zero        <= (load_val.res == '0);
                overflow    <= load_val.v;
                div_by_zero <= load_val.dbz;
                illegal_op  <= load_val.ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (N = 32).
// Directed vector table, hand-written handshake/reset sequences, then random
// operations compared against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int N     = 32;
    localparam int LIMIT = 100;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rem;
        logic        c;
        logic        z;
        logic        v;
        logic        d;
        logic        i;
    } out_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        out_t        exp;
        int          lat;
        string       name;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   opcode = '0;
    logic         in_ready, out_valid;
    logic [N-1:0] result, remainder;
    logic         carry_out, zero, overflow, div_by_zero, illegal_op;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vecs[$];

    alu_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .remainder  (remainder),
        .carry_out  (carry_out),
        .zero       (zero),
        .overflow   (overflow),
        .div_by_zero(div_by_zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.res = result;
        o.rem = remainder;
        o.c   = carry_out;
        o.z   = zero;
        o.v   = overflow;
        o.d   = div_by_zero;
        o.i   = illegal_op;
        return o;
    endfunction

    // Reference model: signed/unsigned 64-bit arithmetic straight from the rules.
    function automatic out_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        out_t        o;
        longint      sa, sb, ua, ub, r;
        logic [63:0] w;
        int          sh;
        o  = '0;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        ua = longint'({32'b0, x});
        ub = longint'({32'b0, y});
        sh = int'(y[4:0]);
        case (op)
            4'd0: begin
                r = sa + sb; w = 64'(ua + ub);
                o.res = w[31:0]; o.c = w[32]; o.v = (r > MAXI) || (r < MINI);
            end
            4'd1: begin
                r = sa - sb; w = 64'(ua - ub);
                o.res = w[31:0]; o.c = (ua < ub); o.v = (r > MAXI) || (r < MINI);
            end
            4'd2: begin
                r = sa * sb; w = 64'(r);
                o.res = w[31:0]; o.rem = w[63:32]; o.v = (r > MAXI) || (r < MINI);
            end
            4'd3: begin
                if (y == 32'h0) begin
                    o.res = 32'hffff_ffff; o.rem = x; o.d = 1'b1;
                end else if (sa == MINI && sb == -1) begin
                    o.res = 32'h8000_0000; o.v = 1'b1;
                end else begin
                    r = sa / sb; w = 64'(r); o.res = w[31:0];
                    r = sa % sb; w = 64'(r); o.rem = w[31:0];
                end
            end
            4'd4: o.res = x & y;
            4'd5: o.res = x | y;
            4'd6: o.res = x ^ y;
            4'd7: o.res = ~(x | y);
            4'd8: begin
                w = 64'(ua) << sh;
                o.res = w[31:0]; o.c = w[32];
            end
            4'd9: begin
                r = sa >>> sh; w = 64'(r);
                o.res = w[31:0]; o.c = (sh == 0) ? 1'b0 : x[sh-1];
            end
            default: o.i = 1'b1;
        endcase
        o.z = (o.res == 32'h0);
        return o;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] res, input logic [31:0] rem,
                                input logic c, input logic z, input logic v, input logic d,
                                input logic i, input int lat, input string name);
        vec_t t;
        t.op = op; t.a = x; t.b = y; t.lat = lat; t.name = name;
        t.exp.res = res; t.exp.rem = rem;
        t.exp.c = c; t.exp.z = z; t.exp.v = v; t.exp.d = d; t.exp.i = i;
        return t;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h0;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // One full transaction: accept, wait for out_valid (bounded), capture, release.
    // With hold=1, in_valid stays high with junk inputs until the result is out.
    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit hold, output out_t got, output int lat);
        @(negedge clk);
        in_valid = 1'b1; opcode = op; a = x; b = y;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        a = $urandom; b = $urandom; opcode = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
            a = $urandom; b = $urandom; opcode = 4'($urandom);
        end
        in_valid = 1'b0;
        check("out_valid_timeout", out_valid, 1'b1);
        got = dut_out();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("release_to_idle", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        out_t got, snap;
        int   lat, exp_lat;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        bit   hold;

        // Reset state while rst_n is held low.
        #3;
        check("reset_state", {in_ready, out_valid, dut_out()}, {2'b10, 69'b0});
        @(negedge clk); rst_n = 1'b1;

        //        op     a             b             result        remainder     c     z     v     d     i     lat name
        vecs.push_back(mk(4'd0, 32'h7fffffff, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1,  "add_ovf"));
        vecs.push_back(mk(4'd0, 32'hffffffff, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1,  "add_carry"));
        vecs.push_back(mk(4'd1, 32'h80000000, 32'h00000001, 32'h7fffffff, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1,  "sub_ovf"));
        vecs.push_back(mk(4'd3, 32'h00000007, 32'hfffffffe, 32'hfffffffd, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 33, "div_7_m2"));
        vecs.push_back(mk(4'd3, 32'hfffffff9, 32'h00000002, 32'hfffffffd, 32'hffffffff, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 33, "div_m7_2"));
        vecs.push_back(mk(4'd3, 32'h00000005, 32'h00000000, 32'hffffffff, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 33, "div_by_zero"));
        vecs.push_back(mk(4'd3, 32'h80000000, 32'hffffffff, 32'h80000000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 33, "div_min_m1"));
        vecs.push_back(mk(4'd2, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 33, "mul_2p32"));
        vecs.push_back(mk(4'd2, 32'hfffffffd, 32'h00000004, 32'hfffffff4, 32'hffffffff, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 33, "mul_m3_4"));
        vecs.push_back(mk(4'd2, 32'h00000000, 32'hfffffffb, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 33, "mul_zero"));
        vecs.push_back(mk(4'd8, 32'h00000003, 32'h0000001f, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  "sll_31"));
        vecs.push_back(mk(4'd8, 32'h00000005, 32'h00000020, 32'h00000005, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  "sll_0"));
        vecs.push_back(mk(4'd9, 32'h8000000f, 32'h00000004, 32'hf8000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  "sra_4"));
        vecs.push_back(mk(4'd7, 32'h00000000, 32'h00000000, 32'hffffffff, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  "nor_0"));
        vecs.push_back(mk(4'd6, 32'h00001234, 32'h00001234, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  "xor_same"));
        vecs.push_back(mk(4'd12,32'h00000001, 32'h00000001, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1,  "illegal_12"));

        foreach (vecs[k]) begin
            do_op(vecs[k].op, vecs[k].a, vecs[k].b, (k % 3 == 1), got, lat);
            check({vecs[k].name, "_out"}, got, vecs[k].exp);
            check({vecs[k].name, "_lat"}, lat, vecs[k].lat);
        end

        // Backpressure: DONE held 5 cycles with in_valid high and inputs moving.
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'd0; a = 32'd10; b = 32'd20;
        @(posedge clk); #1;
        check("bp_first", {out_valid, dut_out()}, {1'b1, model(4'd0, 32'd10, 32'd20)});
        snap = dut_out();
        for (int i = 0; i < 5; i++) begin
            a = $urandom; opcode = 4'($urandom);
            @(posedge clk); #1;
            check("bp_hold", {out_valid, in_ready, dut_out()}, {2'b10, snap});
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_release", {in_ready, out_valid}, 2'b10);

        // Reset ten cycles into a DIV: aborts immediately, nothing delivered.
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("div_busy", {in_ready, out_valid}, 2'b00);
        rst_n = 1'b0;
        #1;
        check("reset_abort", {in_ready, out_valid, dut_out()}, {2'b10, 69'b0});
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("no_result_after_abort", {in_ready, out_valid}, 2'b10);
        do_op(4'd1, 32'd3, 32'd5, 1'b0, got, lat);
        check("sub_after_reset", got, {32'hfffffffe, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("sub_after_reset_lat", lat, 1);

        // Random operations against the reference model.
        for (int i = 0; i < 250; i++) begin
            rop  = 4'($urandom_range(0, 15));
            ra   = rnd_operand();
            rb   = rnd_operand();
            hold = ($urandom_range(0, 3) == 0);
            exp_lat = (rop == 4'd2 || rop == 4'd3) ? 33 : 1;
            do_op(rop, ra, rb, hold, got, lat);
            check($sformatf("rand op%0d a=%h b=%h", rop, ra, rb), got, model(rop, ra, rb));
            check($sformatf("rand_lat op%0d", rop), lat, exp_lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The parameter list SHALL be: N, 32, operand/result width in bits (legal range 4..64).
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port in_valid SHALL be: input, 1 bit, operands and opcode valid.
REQ-005 Port in_ready SHALL be: output, 1 bit, block can accept an operation.
REQ-006 Ports a and b SHALL be: input, N bits each, signed operands.
REQ-007 Port opcode SHALL be: input, 4 bits, operation select.
REQ-008 Port out_valid SHALL be: output, 1 bit, result fields valid.
REQ-009 Port out_ready SHALL be: input, 1 bit, consumer accepts result.
REQ-010 Port result SHALL be: output, N bits, signed primary result.
REQ-011 Port remainder SHALL be: output, N bits, signed secondary result (div remainder / mul high half, else 0).
REQ-012 Flag outputs SHALL be 1 bit each: carry_out, zero, overflow, div_by_zero, illegal_op.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRA; 10-15 illegal.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-015 Accept SHALL occur on a rising edge with in_valid && in_ready; a, b and opcode SHALL be registered at accept and later input changes ignored.
REQ-016 On accept of opcodes 0,1,4-15 the FSM SHALL go IDLE->DONE; out_valid rises 1 cycle after accept.
REQ-017 On accept of MUL or DIV the FSM SHALL go IDLE->BUSY, iterate exactly N cycles (one bit per cycle), then BUSY->DONE; out_valid rises N+1 cycles after accept.
REQ-018 DONE SHALL hold all outputs stable until out_ready=1 on a rising edge, then go DONE->IDLE; out_ready is ignored outside DONE.
REQ-019 ADD/SUB: result = (a±b) mod 2^N; carry_out = unsigned carry out of bit N-1 for ADD, unsigned borrow (a<b) for SUB; overflow = signed overflow.
REQ-020 MUL: signed 2N-bit product; result = low N bits, remainder = high N bits; overflow = 1 when high half is not the sign extension of result; carry_out = 0.
REQ-021 DIV: signed quotient truncated toward zero, remainder takes sign of a; carry_out = 0.
REQ-022 DIV with b=0 SHALL give result = all ones, remainder = a, div_by_zero = 1, overflow = 0, still N+1 cycle latency.
REQ-023 DIV with a = -2^(N-1), b = -1 SHALL give result = -2^(N-1), remainder = 0, overflow = 1.
REQ-024 Logic ops: bitwise on a,b; remainder, carry_out, overflow = 0.
REQ-025 SLL/SRA: shift amount = b[$clog2(N)-1:0]; carry_out = last bit shifted out, 0 for amount 0; overflow = 0.
REQ-026 Illegal opcode SHALL give result = 0, remainder = 0, illegal_op = 1, other flags 0.
REQ-027 zero SHALL equal (result == 0) for every opcode; div_by_zero and illegal_op SHALL be 0 except as stated.
REQ-028 in_valid during BUSY or DONE SHALL be ignored (no accept, no state change).

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, result=0, remainder=0 and all flags 0, regardless of clock.
REQ-030 Reset during BUSY or DONE SHALL abort the operation with no result delivered; first accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 N=32, ADD a=2147483647 b=1 -> result 0x80000000, overflow 1, carry_out 0, zero 0, out_valid 1 cycle after accept.
REQ-032 N=32, DIV a=7 b=-2 -> result -3, remainder 1, out_valid exactly 33 cycles after accept; a=-7 b=2 -> -3, -1.
REQ-033 N=32, DIV a=5 b=0 -> result 0xFFFFFFFF, remainder 5, div_by_zero 1; DIV a=0x80000000 b=-1 -> result 0x80000000, overflow 1.
REQ-034 N=32, MUL a=0x10000 b=0x10000 -> result 0, remainder 1, zero 1, overflow 1; MUL a=-3 b=4 -> result -12, remainder 0xFFFFFFFF, overflow 0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a -> outputs stable, in_ready 0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-DIV at cycle 10 of BUSY -> out_valid 0, in_ready 1 immediately; following SUB a=3 b=5 -> result -2, carry_out 1, overflow 0.
